// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART frame serializer; ports clk, rstn, fifo_empty, fifo_rd_data in; fifo_rd_en, tx, busy, tx_done out
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [CW-1:0] bit_cnt, bit_cnt_d;
  logic stop_cnt, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic par, par_d, tx_d, bit_end;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      shift <= '0;
      par <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_d;
      baud <= baud_d;
      bit_cnt <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      shift <= shift_d;
      par <= par_d;
      tx <= tx_d;
    end
  always_comb begin
    bit_end = baud == BW'(CLKS_PER_BIT - 1);
    state_d = state;
    shift_d = shift;
    par_d = par;
    bit_cnt_d = bit_cnt;
    stop_cnt_d = stop_cnt;
    fifo_rd_en = 1'b0;
    tx_done = 1'b0;
    busy = state != IDLE;
    case (state)
      IDLE: if (!fifo_empty) state_d = FETCH;
      FETCH: begin
        fifo_rd_en = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_rd_data;
        par_d = (^fifo_rd_data) ^ (PARITY_ODD != 0);
        bit_cnt_d = '0;
        stop_cnt_d = 1'b0;
        state_d = START;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift >> 1;
        bit_cnt_d = bit_cnt + 1'b1;
        if (bit_cnt == CW'(DATA_WIDTH - 1)) state_d = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        stop_cnt_d = 1'b1;
        if (stop_cnt == 1'(STOP_BITS - 1)) begin
          tx_done = 1'b1;
          state_d = fifo_empty ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    // baud restarts on every state entry and at each bit boundary
    baud_d = (state_d != state || bit_end) ? '0 : baud + 1'b1;
    // tx is registered from the next-state view so the line changes exactly on state entry
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven check of uart_tx in 8N1, 8E1, 8O1 and 8N2 builds at 4 clk per bit
module tb_uart_tx;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic empty [4];
  logic [7:0] rd_data [4];
  logic rd_en [4];
  logic tx [4];
  logic busy [4];
  logic tx_done [4];
  logic [7:0] q [4][8];
  int cnt [4];
  int head [4];
  int rd_cnt [4];
  int done_cnt [4];
  int total = 0;
  int passed = 0;
  typedef struct {
    int inst;
    logic [7:0] data;
    int nbits;
    logic [11:0] bits;
  } vec_t;
  vec_t vecs [7];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx #(
      .CLKS_PER_BIT(4),
      .DATA_WIDTH(8),
      .PARITY_EN((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD(g == 2 ? 1 : 0),
      .STOP_BITS(g == 3 ? 2 : 1)
    ) dut (
      .clk(clk),
      .rstn(rstn),
      .fifo_empty(empty[g]),
      .fifo_rd_data(rd_data[g]),
      .fifo_rd_en(rd_en[g]),
      .tx(tx[g]),
      .busy(busy[g]),
      .tx_done(tx_done[g])
    );
  end
  always_comb for (int i = 0; i < 4; i++) empty[i] = head[i] >= cnt[i];
  always @(posedge clk)
    for (int i = 0; i < 4; i++) begin
      if (rd_en[i]) begin
        rd_data[i] <= q[i][head[i] % 8];
        head[i] <= head[i] + 1;
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
      if (tx_done[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, i, $time, act, exp);
  endtask
  task automatic push(input int i, input logic [7:0] d);
    q[i][cnt[i] % 8] = d;
    cnt[i]++;
  endtask
  task automatic frame(input int i, input logic [11:0] bits, input int n);
    for (int k = 0; k < n * 4; k++) begin
      if (k > 0) cyc();
      chk("tx_bit", i, 32'(tx[i]), 32'(bits[k / 4]));
      chk("tx_done", i, 32'(tx_done[i]), 32'(k == n * 4 - 1));
      chk("busy", i, 32'(busy[i]), 32'd1);
    end
  endtask
  task automatic lead_in(input int i);
    cyc();
    chk("fetch_rd_en", i, 32'(rd_en[i]), 32'd1);
    chk("fetch_tx", i, 32'(tx[i]), 32'd1);
    cyc();
    chk("load_rd_en", i, 32'(rd_en[i]), 32'd0);
    chk("load_tx", i, 32'(tx[i]), 32'd1);
    chk("load_busy", i, 32'(busy[i]), 32'd1);
    cyc();
  endtask
  initial begin
    int i, r0, d0;
    vecs[0] = '{0, 8'hA5, 10, 12'b00_1101001010};
    vecs[1] = '{1, 8'hA5, 11, 12'b0_10101001010};
    vecs[2] = '{2, 8'hA5, 11, 12'b0_11101001010};
    vecs[3] = '{1, 8'h01, 11, 12'b0_11000000010};
    vecs[4] = '{3, 8'hFF, 11, 12'b0_11111111110};
    vecs[5] = '{0, 8'h00, 10, 12'b00_1000000000};
    vecs[6] = '{2, 8'h00, 11, 12'b0_11000000000};
    for (int j = 0; j < 4; j++) cnt[j] = 1;
    repeat (4) begin
      cyc();
      for (int j = 0; j < 4; j++) begin
        chk("rst_tx", j, 32'(tx[j]), 32'd1);
        chk("rst_rd_en", j, 32'(rd_en[j]), 32'd0);
        chk("rst_busy", j, 32'(busy[j]), 32'd0);
        chk("rst_tx_done", j, 32'(tx_done[j]), 32'd0);
      end
    end
    for (int j = 0; j < 4; j++) cnt[j] = 0;
    cyc();
    rstn = 1'b1;
    cyc();
    for (int v = 0; v < 7; v++) begin
      i = vecs[v].inst;
      r0 = rd_cnt[i];
      d0 = done_cnt[i];
      push(i, vecs[v].data);
      lead_in(i);
      frame(i, vecs[v].bits, vecs[v].nbits);
      cyc();
      chk("idle_busy", i, 32'(busy[i]), 32'd0);
      chk("idle_tx", i, 32'(tx[i]), 32'd1);
      chk("rd_pulses", i, 32'(rd_cnt[i] - r0), 32'd1);
      chk("done_pulses", i, 32'(done_cnt[i] - d0), 32'd1);
    end
    r0 = rd_cnt[0];
    push(0, 8'h55);
    push(0, 8'h0F);
    lead_in(0);
    frame(0, 12'b00_1010101010, 10);
    lead_in(0);
    frame(0, 12'b00_1000011110, 10);
    cyc();
    chk("b2b_idle_busy", 0, 32'(busy[0]), 32'd0);
    chk("b2b_rd_pulses", 0, 32'(rd_cnt[0] - r0), 32'd2);
    push(0, 8'hA5);
    lead_in(0);
    repeat (17) cyc();
    chk("mid_tx_pre", 0, 32'(tx[0]), 32'd0);
    d0 = done_cnt[0];
    #1 rstn = 1'b0;
    #1 chk("mid_tx_async", 0, 32'(tx[0]), 32'd1);
    chk("mid_busy", 0, 32'(busy[0]), 32'd0);
    repeat (3) cyc();
    rstn = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (k % 10 == 0) begin
        chk("post_tx", 0, 32'(tx[0]), 32'd1);
        chk("post_busy", 0, 32'(busy[0]), 32'd0);
      end
    end
    chk("post_no_done", 0, 32'(done_cnt[0] - d0), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
